// File: rtl/pipeline_pkg.sv
// Shared types for the hazard/forwarding controller: mux-select codes,
// controller state encoding and the shadow stage record.
package pipeline_pkg;

  // Record destination field is sized for the widest supported register
  // specifier; narrower specifiers are zero-extended before comparison.
  localparam int unsigned REG_W_MAX = 16;

  localparam logic [1:0] FWD_REGFILE   = 2'b00;
  localparam logic [1:0] FWD_DATAMEM   = 2'b01;
  localparam logic [1:0] FWD_PRIOR_ALU = 2'b10;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_e;

  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic                 mem_read;
    logic [REG_W_MAX-1:0] dest;
  } stage_rec_t;

  localparam stage_rec_t BUBBLE = '0;

endpackage

// File: rtl/forward_select.sv
// Operand-mux select for one source register: EX/MEM result beats MEM/WB,
// register 0 and unused sources always read the register file.
module forward_select
  import pipeline_pkg::*;
(
  input  logic [REG_W_MAX-1:0] src_i,
  input  logic                 uses_i,
  input  stage_rec_t           ex_rec_i,
  input  stage_rec_t           mem_rec_i,
  output logic [1:0]           sel_o
);

  always_comb begin
    sel_o = FWD_REGFILE;
    if (uses_i && (src_i != '0)) begin
      // A load in EX has no ALU result yet; load-use stalling covers it.
      if (ex_rec_i.valid && ex_rec_i.reg_write && !ex_rec_i.mem_read &&
          (ex_rec_i.dest == src_i)) begin
        sel_o = FWD_PRIOR_ALU;
      end else if (mem_rec_i.valid && mem_rec_i.reg_write &&
                   (mem_rec_i.dest == src_i)) begin
        sel_o = FWD_DATAMEM;
      end
    end
  end

endmodule

// File: rtl/hazard_forwarding_controller.sv
// EX-stage forwarding selects, load-use stall and taken-branch flush
// sequencing, driven from shadow copies of the EX and MEM destinations.
module hazard_forwarding_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned NBits        = 5,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBits-1:0] ID_Rs_i,
  input  logic [NBits-1:0] ID_Rt_i,
  input  logic             ID_Uses_Rs_i,
  input  logic             ID_Uses_Rt_i,
  input  logic             ID_RegWrite_i,
  input  logic             ID_MemRead_i,
  input  logic [NBits-1:0] ID_WriteReg_i,
  input  logic             EX_Branch_Taken_i,
  output logic [1:0]       ForwardA_o,
  output logic [1:0]       ForwardB_o,
  output logic             PC_Write_o,
  output logic             IFID_Write_o,
  output logic             IDEX_Bubble_o,
  output logic             Flush_o,
  output logic [CNT_W-1:0] Stall_Count_o
);

  logic [REG_W_MAX-1:0] rs_ext, rt_ext;
  stage_rec_t           id_rec, ex_rec_d, ex_rec_q, mem_rec_q;
  ctrl_state_e          state_q;
  logic [2:0]           fcnt_q;
  logic [CNT_W-1:0]     stall_cnt_q;
  logic [1:0]           fwd_a_d, fwd_b_d, fwd_a_q, fwd_b_q;
  logic                 load_use, flush, stall;

  assign rs_ext = REG_W_MAX'(ID_Rs_i);
  assign rt_ext = REG_W_MAX'(ID_Rt_i);

  assign id_rec = '{valid: 1'b1, reg_write: ID_RegWrite_i,
                    mem_read: ID_MemRead_i, dest: REG_W_MAX'(ID_WriteReg_i)};

  forward_select u_fwd_a (
    .src_i     (rs_ext),
    .uses_i    (ID_Uses_Rs_i),
    .ex_rec_i  (ex_rec_q),
    .mem_rec_i (mem_rec_q),
    .sel_o     (fwd_a_d)
  );

  forward_select u_fwd_b (
    .src_i     (rt_ext),
    .uses_i    (ID_Uses_Rt_i),
    .ex_rec_i  (ex_rec_q),
    .mem_rec_i (mem_rec_q),
    .sel_o     (fwd_b_d)
  );

  assign load_use = ex_rec_q.valid && ex_rec_q.mem_read && (ex_rec_q.dest != '0) &&
                    ((ID_Uses_Rs_i && (rs_ext == ex_rec_q.dest)) ||
                     (ID_Uses_Rt_i && (rt_ext == ex_rec_q.dest)));

  // Flush is held low during reset so all outputs show reset values at once.
  assign flush = !reset && (((state_q == RUN) && EX_Branch_Taken_i) ||
                            (state_q == FLUSH));
  assign stall = load_use && !flush;

  assign ex_rec_d = (stall || flush) ? BUBBLE : id_rec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_rec_q  <= BUBBLE;
      mem_rec_q <= BUBBLE;
      fwd_a_q   <= FWD_REGFILE;
      fwd_b_q   <= FWD_REGFILE;
    end else begin
      ex_rec_q  <= ex_rec_d;
      mem_rec_q <= ex_rec_q;
      fwd_a_q   <= fwd_a_d;
      fwd_b_q   <= fwd_b_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (EX_Branch_Taken_i) begin
            fcnt_q <= 3'(FLUSH_CYCLES - 1);
            if (FLUSH_CYCLES > 1) state_q <= FLUSH;
          end
        end
        FLUSH: begin
          fcnt_q <= fcnt_q - 3'd1;
          if (fcnt_q <= 3'd1) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign ForwardA_o    = fwd_a_q;
  assign ForwardB_o    = fwd_b_q;
  assign PC_Write_o    = !stall;
  assign IFID_Write_o  = !stall;
  assign IDEX_Bubble_o = stall;
  assign Flush_o       = flush;
  assign Stall_Count_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forwarding_controller.sv
// Directed scoreboard bench: each driven cycle pushes its hand-computed
// expected outputs; a negedge monitor pops and compares.
module tb_hazard_forwarding_controller;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    rs = '0, rt = '0, wr = '0;
  logic          us = 1'b0, ut = 1'b0, rw = 1'b0, mr = 1'b0, br = 1'b0;
  logic [1:0]    fa, fb;
  logic          pcw, ifw, bub, fl;
  logic [CW-1:0] cnt;

  typedef struct packed {
    logic [4:0] rs, rt;
    logic       us, ut, rw, mr;
    logic [4:0] wr;
  } instr_t;

  typedef struct packed {
    logic [1:0]    fa, fb;
    logic          st, fl;
    logic [CW-1:0] cnt;
    logic [63:0]   tag;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad = 0;
  logic [CW-1:0] exp_cnt = '0;

  hazard_forwarding_controller #(
    .NBits        (5),
    .FLUSH_CYCLES (2),
    .CNT_W        (CW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .ID_Rs_i           (rs),
    .ID_Rt_i           (rt),
    .ID_Uses_Rs_i      (us),
    .ID_Uses_Rt_i      (ut),
    .ID_RegWrite_i     (rw),
    .ID_MemRead_i      (mr),
    .ID_WriteReg_i     (wr),
    .EX_Branch_Taken_i (br),
    .ForwardA_o        (fa),
    .ForwardB_o        (fb),
    .PC_Write_o        (pcw),
    .IFID_Write_o      (ifw),
    .IDEX_Bubble_o     (bub),
    .Flush_o           (fl),
    .Stall_Count_o     (cnt)
  );

  always #5 clk = ~clk;

  function automatic instr_t mk(input logic [4:0] s, t, input logic u_s, u_t,
                                input logic w, m, input logic [4:0] d);
    mk = '{rs: s, rt: t, us: u_s, ut: u_t, rw: w, mr: m, wr: d};
  endfunction

  task automatic chk(input logic [63:0] tag, input string f,
                     input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h", tag, f, act, want);
    end
  endtask

  // One cycle: drive inputs just after the edge, push what the negedge must see.
  task automatic step(input logic r, input instr_t i, input logic b,
                      input logic [1:0] efa, input logic [1:0] efb,
                      input logic est, input logic efl, input logic [63:0] tag);
    @(posedge clk);
    #1;
    reset = r;
    rs = i.rs; rt = i.rt; us = i.us; ut = i.ut;
    rw = i.rw; mr = i.mr; wr = i.wr; br = b;
    if (r) exp_cnt = '0;
    sb.push_back('{fa: efa, fb: efb, st: est, fl: efl, cnt: exp_cnt, tag: tag});
    if (est && !efl && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, "FwdA",   16'(fa),  16'(e.fa));
      chk(e.tag, "FwdB",   16'(fb),  16'(e.fb));
      chk(e.tag, "PCWr",   16'(pcw), 16'(!e.st));
      chk(e.tag, "IFIDWr", 16'(ifw), 16'(!e.st));
      chk(e.tag, "Bubble", 16'(bub), 16'(e.st));
      chk(e.tag, "Flush",  16'(fl),  16'(e.fl));
      chk(e.tag, "Count",  16'(cnt), 16'(e.cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    instr_t NOP, ADD8, SUB8, OR8, ADD0, RD0, NOUSE, SUB88, LW9, ADD9, LWC;
    NOP   = '0;
    ADD8  = mk(5'd1, 5'd2, 1, 1, 1, 0, 5'd8);
    SUB8  = mk(5'd8, 5'd3, 1, 1, 1, 0, 5'd10);
    OR8   = mk(5'd4, 5'd8, 1, 1, 1, 0, 5'd11);
    ADD0  = mk(5'd1, 5'd2, 1, 1, 1, 0, 5'd0);
    RD0   = mk(5'd0, 5'd0, 1, 1, 1, 0, 5'd12);
    NOUSE = mk(5'd12, 5'd12, 0, 0, 0, 0, 5'd0);
    SUB88 = mk(5'd8, 5'd8, 1, 1, 1, 0, 5'd10);
    LW9   = mk(5'd2, 5'd0, 1, 0, 1, 1, 5'd9);
    ADD9  = mk(5'd9, 5'd9, 1, 1, 1, 0, 5'd13);
    LWC   = mk(5'd9, 5'd0, 1, 0, 1, 1, 5'd9);

    // reset, then reset arriving in the middle of a flush
    step(1, NOP, 0, 2'b00, 2'b00, 0, 0, "RST0");
    step(0, NOP, 0, 2'b00, 2'b00, 0, 0, "REL0");
    step(0, NOP, 1, 2'b00, 2'b00, 0, 1, "BRMID");
    step(1, NOP, 0, 2'b00, 2'b00, 0, 0, "RSTFL");
    step(1, NOP, 0, 2'b00, 2'b00, 0, 0, "RSTHLD");
    step(0, NOP, 0, 2'b00, 2'b00, 0, 0, "REL1");

    // EX/MEM forward into Rs
    step(0, ADD8, 0, 2'b00, 2'b00, 0, 0, "C1");
    step(0, SUB8, 0, 2'b00, 2'b00, 0, 0, "C2");
    step(0, NOP,  0, 2'b10, 2'b00, 0, 0, "EXFWD");

    // MEM/WB forward into Rt, register 0, unused sources
    step(0, ADD8,  0, 2'b00, 2'b00, 0, 0, "D1");
    step(0, NOP,   0, 2'b00, 2'b00, 0, 0, "D2");
    step(0, OR8,   0, 2'b00, 2'b00, 0, 0, "D3");
    step(0, ADD0,  0, 2'b00, 2'b01, 0, 0, "MEMFWD");
    step(0, RD0,   0, 2'b00, 2'b00, 0, 0, "D5");
    step(0, NOUSE, 0, 2'b00, 2'b00, 0, 0, "R0");
    step(0, NOP,   0, 2'b00, 2'b00, 0, 0, "NOUSE");

    // both stages match: EX/MEM wins
    step(0, ADD8,  0, 2'b00, 2'b00, 0, 0, "E1");
    step(0, ADD8,  0, 2'b00, 2'b00, 0, 0, "E2");
    step(0, SUB88, 0, 2'b00, 2'b00, 0, 0, "E3");
    step(0, NOP,   0, 2'b10, 2'b10, 0, 0, "PRIO");

    // load-use: one stall, then data-memory forward on both operands
    step(0, LW9,  0, 2'b00, 2'b00, 0, 0, "F1");
    step(0, ADD9, 0, 2'b00, 2'b00, 1, 0, "LUSTALL");
    step(0, ADD9, 0, 2'b00, 2'b00, 0, 0, "LUREP");
    step(0, NOP,  0, 2'b01, 2'b01, 0, 0, "LUFWD");

    // branch while load-use pending; second branch inside flush ignored
    step(0, LW9,  0, 2'b00, 2'b00, 0, 0, "G1");
    step(0, ADD9, 1, 2'b00, 2'b00, 0, 1, "BRLU");
    step(0, ADD9, 1, 2'b00, 2'b00, 0, 1, "FL2");
    step(0, NOP,  0, 2'b01, 2'b01, 0, 0, "FLEND");
    step(0, NOP,  0, 2'b00, 2'b00, 0, 0, "G5");

    // chained self-dependent loads drive the stall counter to saturation
    step(0, LWC, 0, 2'b00, 2'b00, 0, 0, "H0");
    for (int k = 0; k < 260; k++) begin
      step(0, LWC, 0, (k == 0) ? 2'b00 : 2'b01, 2'b00, 1, 0, "SATST");
      step(0, LWC, 0, 2'b00, 2'b00, 0, 0, "SATRP");
    end
    step(0, NOP, 0, 2'b01, 2'b00, 0, 0, "SATEND");
    step(0, NOP, 0, 2'b00, 2'b00, 0, 0, "SATHLD");

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    if (exp_cnt != '1) begin
      bad++;
      $display("FAIL satmodel cnt=%h want=%h", exp_cnt, {CW{1'b1}});
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_forwarding_controller.md
Name: hazard_forwarding_controller

Overview:
- Pipeline controller that drives the 2-bit selectors of the EX-stage operand muxes: 00 = register file, 01 = data memory (MEM/WB), 10 = prior ALU (EX/MEM).
- Keeps a shadow copy of the EX and MEM destination records, so it needs no pipeline-register taps.
- Detects load-use hazards and stalls the front end for one cycle.
- Sequences a multi-cycle flush after a taken branch.

Parameters:
- NBits, 5, register-specifier width.
- FLUSH_CYCLES, 2, cycles Flush_o stays high per taken branch (range 1..7).
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- ID_Rs_i  in  NBits  source register A of the instruction in ID.
- ID_Rt_i  in  NBits  source register B of the instruction in ID.
- ID_Uses_Rs_i  in  1  ID instruction reads Rs.
- ID_Uses_Rt_i  in  1  ID instruction reads Rt.
- ID_RegWrite_i  in  1  ID instruction writes a register.
- ID_MemRead_i  in  1  ID instruction is a load.
- ID_WriteReg_i  in  NBits  destination register of the ID instruction.
- EX_Branch_Taken_i  in  1  the branch in EX resolved taken.
- ForwardA_o  out  2  operand-A mux select, valid while the instruction is in EX.
- ForwardB_o  out  2  operand-B mux select, valid while the instruction is in EX.
- PC_Write_o  out  1  PC enable.
- IFID_Write_o  out  1  IF/ID register enable.
- IDEX_Bubble_o  out  1  zero the control bits loaded into ID/EX.
- Flush_o  out  1  flush IF/ID and ID/EX.
- Stall_Count_o  out  CNT_W  count of load-use stall cycles.

Behaviour:
- Shadow records ex_rec and mem_rec each hold {valid, reg_write, mem_read, dest}.
- Per edge: mem_rec <= ex_rec; ex_rec <= ID record, or a bubble (all fields 0) when stalling or flushing.
- Forward select, computed in ID and registered into ForwardA_o/ForwardB_o (one-cycle latency, Moore):
  - 10 if ex_rec.valid & reg_write & !mem_read & dest == src & dest != 0.
  - else 01 if mem_rec.valid & reg_write & dest == src & dest != 0.
  - else 00.
  - A matching source whose Uses bit is 0 yields 00.
- EX/MEM has priority over MEM/WB when both match the same source.
- Selector value 11 is never produced.
- Load-use detection, combinational: stall = ex_rec.valid & ex_rec.mem_read & ex_rec.dest != 0 & ((Uses_Rs & Rs == dest) | (Uses_Rt & Rt == dest)).
- During a stall: PC_Write_o = 0, IFID_Write_o = 0, IDEX_Bubble_o = 1.
- After the stall the load sits in mem_rec, so the re-presented ID instruction receives select 01. Exactly one stall cycle per load-use.
- State machine RUN/FLUSH, with a 3-bit counter:
  - In RUN, EX_Branch_Taken_i = 1 makes Flush_o = 1 combinationally, loads the counter with FLUSH_CYCLES-1, and moves to FLUSH if FLUSH_CYCLES > 1.
  - In FLUSH, Flush_o = 1 and the counter decrements; at 0 the next state is RUN.
  - EX_Branch_Taken_i is ignored while in FLUSH (wrong-path instruction).
- Whenever Flush_o = 1: ex_rec loads a bubble, the stall is suppressed (PC_Write_o = 1, IFID_Write_o = 1, IDEX_Bubble_o = 0), and Stall_Count_o does not increment.
- Branch taken and load-use in the same cycle: flush wins.
- Stall_Count_o increments by 1 on each stall cycle and saturates at all-ones.
- Reset, asynchronous, valid at any point including mid-flush or mid-stall:
  - Records invalid, state RUN, counters 0.
  - ForwardA_o = ForwardB_o = 00, PC_Write_o = 1, IFID_Write_o = 1, IDEX_Bubble_o = 0, Flush_o = 0, Stall_Count_o = 0.

Decomposition:
- Shared package (pipeline_pkg):
  - FWD_REGFILE = 2'b00, FWD_DATAMEM = 2'b01, FWD_PRIOR_ALU = 2'b10.
  - State encoding RUN/FLUSH.
  - stage_rec_t struct.
- One natural sub-module: forward_select. It is a pure-combinational compare of one source against ex_rec and mem_rec, returning 2 bits, and is instantiated twice (A and B).

Test Plan:
- Reset mid-flush (branch taken, reset on the next cycle) -> all outputs at reset values immediately; Flush_o = 0 after release.
- ADD writing R8, then SUB reading R8 in Rs -> ForwardA_o = 10 in SUB's EX cycle; ForwardB_o = 00.
- ADD R8, NOP, OR reading R8 in Rt -> ForwardB_o = 01. ADD R0 then a reader of R0 -> 00.
- LW R9, then ADD reading R9 in Rs and Rt:
  - one cycle with PC_Write_o = 0, IFID_Write_o = 0, IDEX_Bubble_o = 1;
  - then ForwardA_o = ForwardB_o = 01;
  - Stall_Count_o = 1.
- EX_Branch_Taken_i pulsed while a load-use is pending, FLUSH_CYCLES = 2 -> Flush_o high for 2 cycles, no stall, Stall_Count_o unchanged; a second Branch_Taken in cycle 2 is ignored.
- 65536 back-to-back load-use pairs -> Stall_Count_o saturates at 16'hFFFF.
